rfm_tracker_mb: RTL and testbench

Multi-bank, parametrised row-activation tracker for the DRAM-side RFM path. It keeps one Space-Saving table per bank and a per-bank rolling accumulated activation (RAA) counter. It raises a per-bank RFM request when the bank's RAA reaches a threshold. On each RFM it selects the hottest tracked row in the addressed bank and emits it as a Nearby-Row-Refresh (NRR) target over a valid/ready handshake. It sits between the command decoder (ACT/RFM stream) and the refresh engine, and replaces the single-bank tracker.

---
 rtl/rfm_tracker_mb_if.sv | 29 ++
 rtl/rfm_tracker_mb.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rfm_tracker_mb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rfm_tracker_mb_if.sv
// Command-in / NRR-out bus of the multi-bank RFM tracker.
// The tracker itself uses the slave modport; the command decoder and refresh engine side uses master.
interface rfm_tracker_mb_if #(
  parameter int NUM_BANK  = 4,
  parameter int BANK_BITS = 2,
  parameter int ADDR_SIZE = 18
);
  logic                 act_vld;
  logic                 rfm_vld;
  logic [BANK_BITS-1:0] cmd_bank;
  logic [ADDR_SIZE-1:0] act_addr;
  logic                 cmd_rdy;
  logic [NUM_BANK-1:0]  rfm_req;
  logic                 nrr_vld;
  logic [BANK_BITS-1:0] nrr_bank;
  logic [ADDR_SIZE-1:0] nrr_addr;
  logic                 nrr_rdy;
  logic                 rfm_done;

  modport master (
    output act_vld, rfm_vld, cmd_bank, act_addr, nrr_rdy,
    input  cmd_rdy, rfm_req, nrr_vld, nrr_bank, nrr_addr, rfm_done
  );

  modport slave (
    input  act_vld, rfm_vld, cmd_bank, act_addr, nrr_rdy,
    output cmd_rdy, rfm_req, nrr_vld, nrr_bank, nrr_addr, rfm_done
  );
endinterface

// File: rtl/rfm_tracker_mb.sv
// Multi-bank Space-Saving row-activation tracker: per-bank tables plus RAA counters,
// RFM request generation and one NRR target per RFM over valid/ready.
module rfm_tracker_mb #(
  parameter int NUM_BANK   = 4,
  parameter int BANK_BITS  = 2,
  parameter int NUM_ENTRY  = 16,
  parameter int ENTRY_BITS = 4,
  parameter int ADDR_SIZE  = 18,
  parameter int CNT_SIZE   = 16,
  parameter int RAA_BITS   = 8,
  parameter int RAAIMT     = 32,
  parameter int NRR_TH     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  rfm_tracker_mb_if.slave       bus
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
  localparam logic [RAA_BITS-1:0] RAA_MAX = '1;
  localparam logic [RAA_BITS-1:0] RAA_DEC = RAA_BITS'(RAAIMT);

  typedef enum logic [2:0] {
    IDLE, ACT_LK, ACT_UPD, RFM_SCAN, RFM_ISSUE, RFM_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [BANK_BITS-1:0]  bank_q, bank_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic                  hit_q, hit_d, free_q, free_d, min_q, min_d;
  logic [ENTRY_BITS-1:0] hit_idx_q, hit_idx_d, free_idx_q, free_idx_d, min_idx_q, min_idx_d;
  logic [ENTRY_BITS-1:0] scan_idx_q, scan_idx_d;
  logic                  found_q, found_d;
  logic [CNT_SIZE-1:0]   max_cnt_q, max_cnt_d;
  logic [ENTRY_BITS-1:0] max_idx_q, max_idx_d;
  logic [ADDR_SIZE-1:0]  max_addr_q, max_addr_d;

  logic                  upd_en, clr_en, dec_en, nrr_ok;
  logic                  cmd_rdy, nrr_vld, rfm_done;
  logic [NUM_BANK-1:0]   bank_sel;

  logic [NUM_BANK-1:0]                  b_hit, b_free, b_min, b_rd_vld, b_req;
  logic [NUM_BANK-1:0][ENTRY_BITS-1:0]  b_hit_idx, b_free_idx, b_min_idx;
  logic [NUM_BANK-1:0][ADDR_SIZE-1:0]   b_rd_addr;
  logic [NUM_BANK-1:0][CNT_SIZE-1:0]    b_rd_cnt, b_spcnt;

  assign bank_sel = NUM_BANK'(1) << bank_q;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [NUM_ENTRY-1:0]                vld_q, vld_d;
    logic [NUM_ENTRY-1:0][ADDR_SIZE-1:0] ent_addr_q, ent_addr_d;
    logic [NUM_ENTRY-1:0][CNT_SIZE-1:0]  cnt_q, cnt_d;
    logic [CNT_SIZE-1:0]                 spcnt_q, spcnt_d, spcnt_inc, hit_cnt, hit_inc;
    logic [RAA_BITS-1:0]                 raa_q, raa_d;
    logic                                lk_hit, lk_free, lk_min;
    logic [ENTRY_BITS-1:0]               lk_hit_idx, lk_free_idx, lk_min_idx;

    assign spcnt_inc = (spcnt_q == CNT_MAX) ? spcnt_q : spcnt_q + CNT_SIZE'(1);
    assign hit_cnt   = cnt_q[hit_idx_q];
    assign hit_inc   = (hit_cnt == CNT_MAX) ? hit_cnt : hit_cnt + CNT_SIZE'(1);

    // Downward sweep so the lowest qualifying index is the one left standing.
    always_comb begin
      lk_hit      = 1'b0;
      lk_free     = 1'b0;
      lk_min      = 1'b0;
      lk_hit_idx  = '0;
      lk_free_idx = '0;
      lk_min_idx  = '0;
      for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
        if (vld_q[i] && ent_addr_q[i] == addr_q) begin
          lk_hit     = 1'b1;
          lk_hit_idx = ENTRY_BITS'(i);
        end
        if (!vld_q[i]) begin
          lk_free     = 1'b1;
          lk_free_idx = ENTRY_BITS'(i);
        end
        if (vld_q[i] && cnt_q[i] == spcnt_q) begin
          lk_min     = 1'b1;
          lk_min_idx = ENTRY_BITS'(i);
        end
      end
    end

    always_comb begin
      vld_d      = vld_q;
      ent_addr_d = ent_addr_q;
      cnt_d      = cnt_q;
      spcnt_d    = spcnt_q;
      raa_d      = raa_q;
      if (upd_en && bank_sel[b]) begin
        if (hit_q) begin
          cnt_d[hit_idx_q] = hit_inc;
        end else if (free_q) begin
          vld_d[free_idx_q]      = 1'b1;
          ent_addr_d[free_idx_q] = addr_q;
          cnt_d[free_idx_q]      = spcnt_inc;
        end else if (min_q) begin
          ent_addr_d[min_idx_q] = addr_q;
          cnt_d[min_idx_q]      = spcnt_inc;
        end else begin
          spcnt_d = spcnt_inc;
        end
        raa_d = (raa_q == RAA_MAX) ? raa_q : raa_q + RAA_BITS'(1);
      end
      if (clr_en && bank_sel[b]) cnt_d[max_idx_q] = spcnt_q;
      if (dec_en && bank_sel[b]) raa_d = (raa_q >= RAA_DEC) ? raa_q - RAA_DEC : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q      <= '0;
        ent_addr_q <= '0;
        cnt_q      <= '0;
        spcnt_q    <= '0;
        raa_q      <= '0;
      end else begin
        vld_q      <= vld_d;
        ent_addr_q <= ent_addr_d;
        cnt_q      <= cnt_d;
        spcnt_q    <= spcnt_d;
        raa_q      <= raa_d;
      end
    end

    assign b_hit[b]      = lk_hit;
    assign b_free[b]     = lk_free;
    assign b_min[b]      = lk_min;
    assign b_hit_idx[b]  = lk_hit_idx;
    assign b_free_idx[b] = lk_free_idx;
    assign b_min_idx[b]  = lk_min_idx;
    assign b_rd_vld[b]   = vld_q[scan_idx_q];
    assign b_rd_addr[b]  = ent_addr_q[scan_idx_q];
    assign b_rd_cnt[b]   = cnt_q[scan_idx_q];
    assign b_spcnt[b]    = spcnt_q;
    assign b_req[b]      = (raa_q >= RAA_DEC);
  end

  // A target only earns an NRR if it stands clear of the spillover floor.
  assign nrr_ok = found_q && (max_cnt_q >= CNT_SIZE'(NRR_TH)) && (max_cnt_q > b_spcnt[bank_q]);

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    hit_d      = hit_q;
    free_d     = free_q;
    min_d      = min_q;
    hit_idx_d  = hit_idx_q;
    free_idx_d = free_idx_q;
    min_idx_d  = min_idx_q;
    scan_idx_d = scan_idx_q;
    found_d    = found_q;
    max_cnt_d  = max_cnt_q;
    max_idx_d  = max_idx_q;
    max_addr_d = max_addr_q;
    cmd_rdy    = 1'b0;
    nrr_vld    = 1'b0;
    rfm_done   = 1'b0;
    upd_en     = 1'b0;
    clr_en     = 1'b0;
    dec_en     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (bus.act_vld) begin
          bank_d  = bus.cmd_bank;
          addr_d  = bus.act_addr;
          state_d = ACT_LK;
        end else if (bus.rfm_vld) begin
          bank_d     = bus.cmd_bank;
          scan_idx_d = '0;
          found_d    = 1'b0;
          max_cnt_d  = '0;
          max_idx_d  = '0;
          state_d    = RFM_SCAN;
        end
      end
      ACT_LK: begin
        hit_d      = b_hit[bank_q];
        free_d     = b_free[bank_q];
        min_d      = b_min[bank_q];
        hit_idx_d  = b_hit_idx[bank_q];
        free_idx_d = b_free_idx[bank_q];
        min_idx_d  = b_min_idx[bank_q];
        state_d    = ACT_UPD;
      end
      ACT_UPD: begin
        upd_en  = 1'b1;
        state_d = IDLE;
      end
      RFM_SCAN: begin
        if (b_rd_vld[bank_q] && (!found_q || b_rd_cnt[bank_q] > max_cnt_q)) begin
          found_d    = 1'b1;
          max_cnt_d  = b_rd_cnt[bank_q];
          max_idx_d  = scan_idx_q;
          max_addr_d = b_rd_addr[bank_q];
        end
        if (scan_idx_q == ENTRY_BITS'(NUM_ENTRY - 1)) state_d = RFM_ISSUE;
        else scan_idx_d = scan_idx_q + ENTRY_BITS'(1);
      end
      RFM_ISSUE: begin
        if (nrr_ok) begin
          nrr_vld = 1'b1;
          if (bus.nrr_rdy) begin
            clr_en  = 1'b1;
            state_d = RFM_DONE;
          end
        end else begin
          state_d = RFM_DONE;
        end
      end
      RFM_DONE: begin
        rfm_done = 1'b1;
        dec_en   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      free_q     <= 1'b0;
      min_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_idx_q <= '0;
      min_idx_q  <= '0;
      scan_idx_q <= '0;
      found_q    <= 1'b0;
      max_cnt_q  <= '0;
      max_idx_q  <= '0;
      max_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      free_q     <= free_d;
      min_q      <= min_d;
      hit_idx_q  <= hit_idx_d;
      free_idx_q <= free_idx_d;
      min_idx_q  <= min_idx_d;
      scan_idx_q <= scan_idx_d;
      found_q    <= found_d;
      max_cnt_q  <= max_cnt_d;
      max_idx_q  <= max_idx_d;
      max_addr_q <= max_addr_d;
    end
  end

  assign bus.cmd_rdy  = cmd_rdy;
  assign bus.rfm_req  = b_req;
  assign bus.nrr_vld  = nrr_vld;
  assign bus.nrr_bank = bank_q;
  assign bus.nrr_addr = max_addr_q;
  assign bus.rfm_done = rfm_done;

endmodule

// File: tb/tb_rfm_tracker_mb.sv
// Bench for rfm_tracker_mb: directed scenarios then random ACT/RFM traffic,
// checked cycle by cycle against an array-based Space-Saving model.
module tb_rfm_tracker_mb;
  localparam int NB = 4, BB = 2, NE = 16, EB = 4, AS = 18;
  localparam int CS = 4, RB = 8, IMT = 32, NTH = 2;
  localparam int CMAX = (1 << CS) - 1, RMAX = (1 << RB) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rfm_tracker_mb_if #(.NUM_BANK(NB), .BANK_BITS(BB), .ADDR_SIZE(AS)) bif ();

  rfm_tracker_mb #(
    .NUM_BANK(NB), .BANK_BITS(BB), .NUM_ENTRY(NE), .ENTRY_BITS(EB), .ADDR_SIZE(AS),
    .CNT_SIZE(CS), .RAA_BITS(RB), .RAAIMT(IMT), .NRR_TH(NTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_vld [NB][NE];
  int m_addr[NB][NE];
  int m_cnt [NB][NE];
  int m_sp  [NB];
  int m_raa [NB];

  logic          last_vld;
  logic [AS-1:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int b = 0; b < NB; b++) begin
      m_sp[b]  = 0;
      m_raa[b] = 0;
      for (int i = 0; i < NE; i++) begin
        m_vld[b][i] = 0; m_addr[b][i] = 0; m_cnt[b][i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] m_req();
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) if (m_raa[b] >= IMT) r[b] = 1'b1;
    return r;
  endfunction

  // Space-Saving update: hit, else first free slot, else first slot sitting at the floor, else raise floor.
  task automatic m_act(input int b, input int a);
    int hit, fr, mn;
    hit = -1; fr = -1; mn = -1;
    for (int i = 0; i < NE; i++) begin
      if (hit < 0 && m_vld[b][i] != 0 && m_addr[b][i] == a) hit = i;
      if (fr < 0 && m_vld[b][i] == 0) fr = i;
      if (mn < 0 && m_vld[b][i] != 0 && m_cnt[b][i] == m_sp[b]) mn = i;
    end
    if (hit >= 0) m_cnt[b][hit] = (m_cnt[b][hit] + 1 > CMAX) ? CMAX : m_cnt[b][hit] + 1;
    else if (fr >= 0) begin
      m_vld[b][fr] = 1; m_addr[b][fr] = a;
      m_cnt[b][fr] = (m_sp[b] + 1 > CMAX) ? CMAX : m_sp[b] + 1;
    end else if (mn >= 0) begin
      m_addr[b][mn] = a;
      m_cnt[b][mn] = (m_sp[b] + 1 > CMAX) ? CMAX : m_sp[b] + 1;
    end else m_sp[b] = (m_sp[b] + 1 > CMAX) ? CMAX : m_sp[b] + 1;
    m_raa[b] = (m_raa[b] + 1 > RMAX) ? RMAX : m_raa[b] + 1;
  endtask

  task automatic do_act(input int b, input int a);
    chk("act_idle", bif.cmd_rdy, 1);
    bif.act_vld = 1'b1; bif.cmd_bank = BB'(b); bif.act_addr = AS'(a);
    @(negedge clk);
    bif.act_vld = 1'b0;
    chk("act_busy", bif.cmd_rdy, 0);
    repeat (2) @(negedge clk);
    m_act(b, a);
    chk("act_rdy_back", bif.cmd_rdy, 1);
    chk("act_rfm_req", bif.rfm_req, m_req());
  endtask

  task automatic do_rfm(input int b, input int hold);
    int best;
    bit emit;
    best = -1;
    for (int i = 0; i < NE; i++)
      if (m_vld[b][i] != 0 && (best < 0 || m_cnt[b][i] > m_cnt[b][best])) best = i;
    emit = (best >= 0) && (m_cnt[b][best] >= NTH) && (m_cnt[b][best] > m_sp[b]);
    chk("rfm_idle", bif.cmd_rdy, 1);
    bif.rfm_vld = 1'b1; bif.cmd_bank = BB'(b);
    bif.nrr_rdy = (hold == 0);
    @(negedge clk);
    bif.rfm_vld = 1'b0;
    chk("rfm_busy", bif.cmd_rdy, 0);
    repeat (NE - 1) @(negedge clk);
    chk("scan_nrr_quiet", bif.nrr_vld, 0);
    @(negedge clk);
    last_vld  = bif.nrr_vld;
    last_addr = bif.nrr_addr;
    if (emit) begin
      chk("nrr_vld", bif.nrr_vld, 1);
      chk("nrr_bank", bif.nrr_bank, b);
      chk("nrr_addr", bif.nrr_addr, m_addr[b][best]);
      chk("issue_no_done", bif.rfm_done, 0);
      for (int i = 1; i <= hold; i++) begin
        @(negedge clk);
        chk("hold_vld", bif.nrr_vld, 1);
        chk("hold_addr", bif.nrr_addr, m_addr[b][best]);
        chk("hold_bank", bif.nrr_bank, b);
        chk("hold_cmd_rdy", bif.cmd_rdy, 0);
      end
      bif.nrr_rdy = 1'b1;
      @(negedge clk);
      m_cnt[b][best] = m_sp[b];
    end else begin
      chk("no_nrr_vld", bif.nrr_vld, 0);
      chk("no_nrr_done_early", bif.rfm_done, 0);
      @(negedge clk);
      chk("no_nrr_vld_late", bif.nrr_vld, 0);
    end
    chk("rfm_done", bif.rfm_done, 1);
    chk("done_nrr_low", bif.nrr_vld, 0);
    m_raa[b] = (m_raa[b] >= IMT) ? m_raa[b] - IMT : 0;
    bif.nrr_rdy = 1'b1;
    @(negedge clk);
    chk("done_pulse_once", bif.rfm_done, 0);
    chk("rfm_rdy_back", bif.cmd_rdy, 1);
    chk("rfm_req_after", bif.rfm_req, m_req());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_rdy"}, bif.cmd_rdy, 1);
    chk({tag, "_rfm_req"}, bif.rfm_req, 0);
    chk({tag, "_nrr_vld"}, bif.nrr_vld, 0);
    chk({tag, "_nrr_bank"}, bif.nrr_bank, 0);
    chk({tag, "_nrr_addr"}, bif.nrr_addr, 0);
    chk({tag, "_rfm_done"}, bif.rfm_done, 0);
  endtask

  initial begin
    bif.act_vld = 1'b0; bif.rfm_vld = 1'b0; bif.cmd_bank = '0; bif.act_addr = '0;
    bif.nrr_rdy = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // Repeated row in bank 1 becomes the NRR target and is cleared afterwards.
    repeat (3) do_act(1, 'h00AA);
    do_rfm(1, 0);
    chk("hot_row_addr", last_addr, 18'h00AA);

    // Fill bank 0, then overflow it so the floor rises and floor entries get replaced.
    for (int i = 0; i < NE; i++) do_act(0, 'h1000 + i);
    do_act(0, 'h2000);
    do_act(0, 'h2001);
    do_act(0, 'h2002);
    do_rfm(0, 0);
    chk("ss_replace_pick", last_addr, 18'h2001);

    // RAA threshold, full decrement, and partial decrement.
    for (int i = 0; i < 32; i++) do_act(2, 'h200 + (i % 5));
    chk("req_bank2", bif.rfm_req, 4'b0100);
    do_rfm(2, 0);
    chk("req_clear_bank2", bif.rfm_req, 4'b0000);
    for (int i = 0; i < 40; i++) do_act(3, 'h300 + (i % 3));
    do_rfm(3, 0);
    chk("req_after_40", bif.rfm_req, 4'b0000);
    for (int i = 0; i < 24; i++) do_act(3, 'h300 + (i % 3));
    chk("raa_remainder_8", bif.rfm_req, 4'b1000);
    do_rfm(3, 0);

    // Bank whose hottest row sits below NRR_TH: no NRR, done two cycles after scan.
    do_act(1, 'h01BB);
    do_rfm(1, 0);
    chk("below_th_no_nrr", last_vld, 0);

    // Back-pressured NRR, then simultaneous ACT+RFM where ACT must win.
    repeat (3) do_act(3, 'h3C0);
    do_rfm(3, 5);
    chk("bp_nrr_seen", last_vld, 1);
    bif.act_vld = 1'b1; bif.rfm_vld = 1'b1; bif.cmd_bank = 2'd3; bif.act_addr = 18'h3C1;
    @(negedge clk);
    bif.act_vld = 1'b0;
    chk("both_busy", bif.cmd_rdy, 0);
    repeat (2) @(negedge clk);
    m_act(3, 'h3C1);
    chk("both_act_first", bif.cmd_rdy, 1);
    chk("both_req", bif.rfm_req, m_req());
    do_rfm(3, 0);

    // Random mixed traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int b, a, r;
      r = $urandom_range(0, 9);
      b = $urandom_range(0, NB - 1);
      a = 'h100 + $urandom_range(0, 19);
      if (r < 8) do_act(b, a);
      else do_rfm(b, $urandom_range(0, 3));
    end

    // Counter saturation: the saturated row ties the second row and wins on index.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
    @(negedge clk);
    repeat (20) do_act(0, 'h3A5);
    repeat (16) do_act(0, 'h15A);
    do_rfm(0, 0);
    chk("sat_pick", last_addr, 18'h3A5);

    // Reset in the middle of a scan.
    repeat (3) do_act(0, 'h0777);
    bif.rfm_vld = 1'b1; bif.cmd_bank = 2'd0;
    @(negedge clk);
    bif.rfm_vld = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_scan_reset");
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
    @(negedge clk);
    chk_reset_outputs("after_mid_reset");
    do_rfm(0, 0);
    chk("table_cleared", last_vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
